// File: rtl/pingpong_conv_reader.sv
// Consumer-side reader for the ping-pong line buffer: sweeps a filled bank and streams it to the PE.
// Optional feature: define PPB_READER_FRAME_CNT_EN to build the 16-bit completed-frame counter.
module pingpong_conv_reader #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_buf_ready,
  output logic [ADDR_W-1:0] o_conv_addr,
  input  logic [DATA_W-1:0] i_conv_dout,
  output logic              o_switch_pingpong,
  output logic [DATA_W-1:0] o_data,
  output logic              o_data_vld,
  input  logic              i_data_rdy,
  output logic              o_data_last,
  output logic              o_busy,
  output logic [15:0]       o_frame_cnt
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StHoldoff} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              hold_q;
  logic              sw_q;
  logic              rd_vld_q, rd_last_q;
  logic [2:0]        fifo_cnt_q;
  logic [1:0]        wr_ptr_q, rd_ptr_q;
  logic [DATA_W:0]   fifo_mem_q [4];
  logic              issue, issue_last, push, pop, head_last, frame_done;

  // A read is in flight for exactly one cycle (data on i_conv_dout) before it lands in the FIFO,
  // so reserving a slot for it keeps the 4-entry FIFO from ever overflowing.
  assign issue      = (state_q == StRead) && i_en &&
                      ((4'(fifo_cnt_q) + 4'(rd_vld_q)) <= 4'd3);
  assign issue_last = issue && (addr_q == LastAddr);
  assign push       = rd_vld_q;
  assign pop        = o_data_vld && i_data_rdy;
  assign head_last  = fifo_mem_q[rd_ptr_q][DATA_W];
  assign frame_done = (state_q == StDrain) && pop && head_last && !rd_vld_q;

  // FSM: state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (i_buf_ready && i_en) state_d = StRead;
      StRead:    if (issue_last) state_d = StDrain;
      StDrain:   if (frame_done) state_d = StHoldoff;
      StHoldoff: if (hold_q) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    o_busy = (state_q != StIdle);
  end

  always_comb begin
    addr_d = addr_q;
    if (issue && !issue_last) begin
      addr_d = addr_q + ADDR_W'(1);
    end
    if ((state_q == StHoldoff) && hold_q) begin
      addr_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr_q    <= '0;
      hold_q    <= 1'b0;
      sw_q      <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_last_q <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      hold_q    <= (state_q == StHoldoff) ? ~hold_q : 1'b0;
      rd_vld_q  <= issue;
      rd_last_q <= issue_last;
      if (frame_done) begin
        sw_q <= ~sw_q;
      end
    end
  end

  // Output FIFO; entries carry the last-beat tag in the MSB.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 4; i++) begin
        fifo_mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) begin
        fifo_mem_q[wr_ptr_q] <= {rd_last_q, i_conv_dout};
        wr_ptr_q             <= wr_ptr_q + 2'd1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 2'd1;
      end
      unique case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 3'd1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 3'd1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

`ifdef PPB_READER_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      frame_cnt_q <= '0;
    end else if (frame_done) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign o_frame_cnt = frame_cnt_q;
`else
  assign o_frame_cnt = 16'd0;
`endif

  assign o_conv_addr       = addr_q;
  assign o_switch_pingpong = sw_q;
  assign o_data            = fifo_mem_q[rd_ptr_q][DATA_W-1:0];
  assign o_data_vld        = (fifo_cnt_q != 3'd0);
  assign o_data_last       = o_data_vld && head_last;

endmodule
